// File: rtl/fifo_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_pkg
// Description : Shared types and constants for the FIFO burst reader.
//               rd_state_t  - burst reader FSM state encoding
//               BUF_DEPTH   - depth of the read-side skid buffer
//               CNT_WIDTH   - width of the skid buffer occupancy count
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_burst_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage : fifo_burst_pkg
`default_nettype wire

// File: rtl/fifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_skid
// Description : BUF_DEPTH-entry first-in first-out holding buffer that absorbs
//               the FIFO read latency in front of a stalling stream.
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   i_push       in   write i_push_data at the tail
//   i_push_data  in   data to write
//   i_pop        in   remove the head entry
//   o_head_data  out  oldest buffered word
//   o_count      out  number of buffered words
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_skid
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [CNT_WIDTH-1:0]  o_count
);

    localparam int PTR_WIDTH = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_pop;
    logic                  w_push;

    // A pop on an empty buffer is meaningless; a push into a full buffer is
    // only legal when the head leaves in the same cycle (its slot is reused).
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CNT_WIDTH'(BUF_DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= (r_wr_ptr == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_WIDTH'(BUF_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule : fifo_rd_skid
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : Drains exactly i_Len words from a synchronous FIFO read port
//               (one-cycle read latency) onto a valid/ready stream with a
//               last-word marker, pulsing o_Done once the burst is accepted.
//   i_Clk              in   clock, rising edge
//   i_Reset            in   synchronous active-high reset
//   i_Start            in   burst request, sampled only in IDLE
//   i_Len              in   burst length, captured with i_Start
//   o_Busy             out  high whenever not IDLE
//   o_Done             out  one-cycle pulse after the final word is accepted
//   i_Fifo_Empty       in   FIFO empty flag
//   i_Fifo_Rd_Data     in   FIFO read data
//   i_Fifo_Data_Valid  in   FIFO read data valid (one cycle after a strobe)
//   o_Fifo_Rd_En       out  FIFO read strobe
//   o_Data             out  stream data (buffer head)
//   o_Valid            out  stream valid
//   i_Ready            in   stream ready
//   o_Last             out  marks the final word of the burst
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_burst_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic [LEN_WIDTH-1:0]  i_Len,
    output logic                  o_Busy,
    output logic                  o_Done,
    input  logic                  i_Fifo_Empty,
    input  logic [DATA_WIDTH-1:0] i_Fifo_Rd_Data,
    input  logic                  i_Fifo_Data_Valid,
    output logic                  o_Fifo_Rd_En,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Last
);

    localparam int SUM_WIDTH = CNT_WIDTH + 1;

    rd_state_t             r_state;
    rd_state_t             w_state_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issued;
    logic [LEN_WIDTH-1:0]  r_accepted;
    logic                  r_inflight;
    logic                  r_busy;
    logic                  r_done;

    logic [CNT_WIDTH-1:0]  w_count;
    logic [SUM_WIDTH-1:0]  w_credit_sum;
    logic                  w_credit_ok;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_at_last;
    logic                  w_final_pop;
    logic                  w_rd_en;
    logic                  w_start;

    // ------------------------------------------------------------------------
    // Skid buffer: only data that answers one of our own strobes is accepted,
    // so stray valids (e.g. after a reset mid-burst) are dropped.
    // ------------------------------------------------------------------------
    assign w_push = i_Fifo_Data_Valid && r_inflight;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (i_Clk),
        .rst         (i_Reset),
        .i_push      (w_push),
        .i_push_data (i_Fifo_Rd_Data),
        .i_pop       (w_pop),
        .o_head_data (o_Data),
        .o_count     (w_count)
    );

    assign o_Valid     = (w_count != '0);
    assign w_pop       = o_Valid && i_Ready;
    assign w_at_last   = (r_accepted == (r_len - LEN_WIDTH'(1)));
    assign o_Last      = o_Valid && w_at_last;
    assign w_final_pop = w_pop && w_at_last;
    assign w_start     = (r_state == IDLE) && i_Start;

    // Words buffered plus the one possibly in flight, less the one leaving
    // this cycle, must leave room for the word a new strobe would bring back.
    assign w_credit_sum = SUM_WIDTH'(w_count) + SUM_WIDTH'(r_inflight) - SUM_WIDTH'(w_pop);
    assign w_credit_ok  = (w_credit_sum < SUM_WIDTH'(BUF_DEPTH));

    // ------------------------------------------------------------------------
    // Next-state and read strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_Start) begin
                    w_state_next = (i_Len == '0) ? DONE : READ;
                end
            end
            READ: begin
                w_rd_en = !i_Fifo_Empty && (r_issued < r_len) && w_credit_ok;
                if (w_final_pop) begin
                    w_state_next = DONE;
                end else if (w_rd_en && ((r_issued + LEN_WIDTH'(1)) == r_len)) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_final_pop) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_Fifo_Rd_En = w_rd_en;

    // ------------------------------------------------------------------------
    // State, counters and registered status outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_rd_en;
            r_busy     <= (w_state_next != IDLE);
            r_done     <= (w_state_next == DONE);
            if (w_start) begin
                r_len      <= i_Len;
                r_issued   <= '0;
                r_accepted <= '0;
            end else begin
                if (w_rd_en) begin
                    r_issued <= r_issued + LEN_WIDTH'(1);
                end
                if (w_pop) begin
                    r_accepted <= r_accepted + LEN_WIDTH'(1);
                end
            end
        end
    end

    assign o_Busy = r_busy;
    assign o_Done = r_done;

endmodule : fifo_burst_reader
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader. A behavioural FIFO
//               with one-cycle read latency feeds the DUT; expected stream
//               words are queued when each burst is launched and compared as
//               the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] len = '0;
    logic          ready = 1'b0;
    logic          o_busy, o_done, o_rd_en, o_valid, o_last;
    logic [DW-1:0] o_data;

    // Behavioural FIFO: read data and valid appear one cycle after a strobe.
    logic [DW-1:0] fmem [0:63];
    int            wr_idx = 0;
    int            rd_idx = 0;
    logic [DW-1:0] f_rdata = '0;
    logic          f_valid = 1'b0;
    logic          f_empty;

    assign f_empty = (wr_idx == rd_idx);

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        f_valid <= 1'b0;
        if (o_rd_en && !f_empty) begin
            f_rdata <= fmem[rd_idx];
            f_valid <= 1'b1;
            rd_idx  <= rd_idx + 1;
        end
    end

    fifo_burst_reader #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .i_Clk             (clk),
        .i_Reset           (rst),
        .i_Start           (start),
        .i_Len             (len),
        .o_Busy            (o_busy),
        .o_Done            (o_done),
        .i_Fifo_Empty      (f_empty),
        .i_Fifo_Rd_Data    (f_rdata),
        .i_Fifo_Data_Valid (f_valid),
        .o_Fifo_Rd_En      (o_rd_en),
        .o_Data            (o_data),
        .o_Valid           (o_valid),
        .i_Ready           (ready),
        .o_Last            (o_last)
    );

    // Scoreboard and bookkeeping
    logic [DW-1:0] sb [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            rd_total = 0;
    int            pop_total = 0;
    int            occ = 0;
    int            last_pop_cyc = -1;
    int            first_valid_cyc = -1;
    int            done_cyc = -1;
    int            t0 = 0;
    int            rd0 = 0;
    int            pop0 = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic          s_busy, s_done, s_rd, s_valid, s_last;
    logic [DW-1:0] s_data;
    int            s_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge: records outputs, pops/compares the
    // scoreboard and checks the stream-hold and credit invariants.
    task automatic monitor();
        logic [DW-1:0] e;
        logic          pop;
        s_busy  = o_busy;
        s_done  = o_done;
        s_rd    = o_rd_en;
        s_valid = o_valid;
        s_last  = o_last;
        s_data  = o_data;
        s_cyc   = cyc;
        if (rst) begin
            occ       = 0;
            prev_hold = 1'b0;
            return;
        end
        pop = o_valid && ready;
        if (o_rd_en) begin
            rd_total++;
            chk("rd_en_when_empty", 32'(f_empty), 0);
        end
        if (prev_hold) begin
            chk("hold_valid", 32'(o_valid), 1);
            chk("hold_data", 32'(o_data), 32'(prev_data));
            chk("hold_last", 32'(o_last), 32'(prev_last));
        end
        if (!o_valid) chk("last_without_valid", 32'(o_last), 0);
        occ = occ + int'(o_rd_en) - int'(pop);
        if (o_rd_en) chk("credit_le_2", 32'(occ <= 2), 1);
        if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (pop) begin
            pop_total++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $error("FAIL unexpected_word: observed 0x%0h expected no word", o_data);
            end else begin
                e = sb.pop_front();
                chk("data", 32'(o_data), 32'(e));
                chk("last", 32'(o_last), 32'(sb.size() == 0));
            end
        end
        prev_hold = o_valid && !pop;
        prev_data = o_data;
        prev_last = o_last;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [DW-1:0] v);
        fmem[wr_idx] = v;
        wr_idx++;
    endtask

    task automatic start_burst(input int n);
        rd0             = rd_total;
        pop0            = pop_total;
        first_valid_cyc = -1;
        start           = 1'b1;
        len             = LW'(n);
        t0              = cyc;
        step();
        start           = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit bp);
        done_cyc = -1;
        for (int k = 0; k < bound; k++) begin
            if (bp) ready = ((k % 4) == 0) || ((k % 4) == 3);
            step();
            if (s_done) begin
                done_cyc = s_cyc;
                break;
            end
        end
        if (done_cyc < 0) begin
            n_vec++;
            n_err++;
            $error("FAIL done_timeout: observed no done expected done within %0d cycles", bound);
        end
    endtask

    task automatic finish_checks(input int n);
        chk("done_after_last_pop", 32'(done_cyc), 32'(last_pop_cyc + 1));
        chk("busy_at_done", 32'(s_busy), 1);
        chk("read_strobes", 32'(rd_total - rd0), 32'(n));
        chk("words_accepted", 32'(pop_total - pop0), 32'(n));
        chk("scoreboard_empty", 32'(sb.size()), 0);
        ready = 1'b1;
        step();
        chk("busy_after_done", 32'(s_busy), 0);
        chk("done_one_cycle", 32'(s_done), 0);
    endtask

    initial begin
        // ---------------- reset state
        step();
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_rd_en", 32'(s_rd), 0);
        chk("rst_valid", 32'(s_valid), 0);
        chk("rst_last", 32'(s_last), 0);
        chk("rst_data", 32'(s_data), 0);
        rst = 1'b0;
        step();

        // ---------------- basic burst
        fifo_write(8'h11); fifo_write(8'h22); fifo_write(8'h33); fifo_write(8'h44);
        sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
        ready = 1'b1;
        start_burst(4);
        wait_done(40, 1'b0);
        chk("first_valid_latency", 32'(first_valid_cyc), 32'(t0 + 3));
        chk("full_throughput", 32'(last_pop_cyc), 32'(t0 + 6));
        finish_checks(4);

        // ---------------- backpressure
        fifo_write(8'hA1); fifo_write(8'hA2); fifo_write(8'hA3); fifo_write(8'hA4);
        sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3); sb.push_back(8'hA4);
        start_burst(4);
        wait_done(80, 1'b1);
        finish_checks(4);

        // ---------------- underflow stall
        fifo_write(8'h66); fifo_write(8'h77);
        sb.push_back(8'h66); sb.push_back(8'h77); sb.push_back(8'h55);
        ready = 1'b1;
        start_burst(3);
        for (int k = 0; k < 10; k++) step();
        chk("stall_rd_en", 32'(s_rd), 0);
        chk("stall_busy", 32'(s_busy), 1);
        chk("stall_valid", 32'(s_valid), 0);
        chk("stall_reads", 32'(rd_total - rd0), 2);
        fifo_write(8'h55);
        wait_done(20, 1'b0);
        finish_checks(3);

        // ---------------- zero length
        start_burst(0);
        step();
        chk("len0_done", 32'(s_done), 1);
        chk("len0_valid", 32'(s_valid), 0);
        step();
        chk("len0_done_clear", 32'(s_done), 0);
        chk("len0_busy_clear", 32'(s_busy), 0);
        chk("len0_reads", 32'(rd_total - rd0), 0);

        // ---------------- starts ignored while busy
        fifo_write(8'hC1); fifo_write(8'hC2); fifo_write(8'hC3);
        fifo_write(8'hC4); fifo_write(8'hC5);
        sb.push_back(8'hC1); sb.push_back(8'hC2); sb.push_back(8'hC3);
        start_burst(3);
        start = 1'b1;
        len   = 8'd7;
        step();
        step();
        start = 1'b0;
        wait_done(40, 1'b0);
        finish_checks(3);

        // ---------------- reset mid-burst
        fifo_write(8'hD1); fifo_write(8'hD2); fifo_write(8'hD3); fifo_write(8'hD4);
        sb.push_back(8'hD1); sb.push_back(8'hD2); sb.push_back(8'hD3); sb.push_back(8'hD4);
        start_burst(4);
        for (int k = 0; k < 20 && (rd_total - rd0) < 2; k++) step();
        chk("two_strobes_before_reset", 32'(rd_total - rd0), 2);
        rst = 1'b1;
        sb.delete();
        step();
        rst = 1'b0;
        step();
        chk("mrst_busy", 32'(s_busy), 0);
        chk("mrst_done", 32'(s_done), 0);
        chk("mrst_rd_en", 32'(s_rd), 0);
        chk("mrst_valid", 32'(s_valid), 0);
        chk("mrst_last", 32'(s_last), 0);
        chk("mrst_data", 32'(s_data), 0);
        fifo_write(8'hE1); fifo_write(8'hE2);
        sb.push_back(fmem[rd_idx]);
        sb.push_back(fmem[rd_idx + 1]);
        start_burst(2);
        wait_done(40, 1'b0);
        finish_checks(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_burst_reader
`default_nettype wire
